// File: rtl/ila_readout_ctrl.sv
// ila_readout_ctrl: drains the ILA sample buffer onto a valid/ready stream.
// For every part of every sample it writes INDEX/VALUE_SELECT, waits the
// buffer read latency, captures value_i and offers it as one stream beat.
// Optional build macro ILA_READOUT_HEADER_EN: emit one header beat
// ({8'b0, n_parts[7:0], count[15:0]}, needs DATA_W >= 24) ahead of the data.
module ila_readout_ctrl #(
  parameter int DATA_W   = 32,
  parameter int BUFFER_W = 10,
  parameter int SEL_W    = 4,
  parameter int RD_LAT   = 2
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [BUFFER_W-1:0] start_index_i,
  input  logic [BUFFER_W:0]   count_i,
  input  logic [SEL_W-1:0]    n_parts_i,
  output logic                index_wen_o,
  output logic [BUFFER_W-1:0] index_o,
  output logic                sel_wen_o,
  output logic [SEL_W-1:0]    sel_o,
  input  logic [DATA_W-1:0]   value_i,
  output logic [DATA_W-1:0]   tdata_o,
  output logic                tvalid_o,
  input  logic                tready_i,
  output logic                tlast_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                aborted_o
);

  localparam int REM_W  = BUFFER_W + 1;
  localparam int WCNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [WCNT_W-1:0] WAIT_LOAD = WCNT_W'(RD_LAT - 1);

  typedef enum logic [2:0] {
    IDLE,
    SET,
    WAIT,
    SEND,
    DONE
  } state_t;

  state_t              state, state_nxt;
  logic [BUFFER_W-1:0] idx, idx_nxt;
  logic [SEL_W-1:0]    part, part_nxt;
  logic [SEL_W-1:0]    parts, parts_nxt;
  logic [REM_W-1:0]    remaining, remaining_nxt;
  logic [WCNT_W-1:0]   wait_cnt, wait_cnt_nxt;
  logic                abort_pend, abort_pend_nxt;
  logic                aborted, aborted_nxt;
  logic                hdr, hdr_nxt;
  logic [DATA_W-1:0]   data, data_nxt;

  logic last_part;
  logic last_sample;

  // A part count of 0 is treated as a single part per sample.
  function automatic logic [SEL_W-1:0] eff_parts(input logic [SEL_W-1:0] n);
    return (n == '0) ? SEL_W'(1) : n;
  endfunction

`ifdef ILA_READOUT_HEADER_EN
  // Header beat layout: [15:0] count (truncated), [23:16] parts, rest zero.
  function automatic logic [DATA_W-1:0] header_word(input logic [REM_W-1:0] cnt,
                                                    input logic [SEL_W-1:0] np);
    logic [DATA_W-1:0] w;
    w        = '0;
    w[15:0]  = 16'(cnt);
    w[23:16] = 8'(np);
    return w;
  endfunction
`endif

  assign last_part   = (part == (parts - SEL_W'(1)));
  assign last_sample = (remaining == REM_W'(1));

  assign index_wen_o = (state == SET);
  assign sel_wen_o   = (state == SET);
  assign index_o     = idx;
  assign sel_o       = part;
  assign tdata_o     = data;
  assign tvalid_o    = (state == SEND);
  assign tlast_o     = (state == SEND) && !hdr && last_part && last_sample;
  assign busy_o      = (state != IDLE);
  assign done_o      = (state == DONE);
  assign aborted_o   = aborted;

  // State register and all sequencing counters; reset clears everything.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      idx        <= '0;
      part       <= '0;
      parts      <= '0;
      remaining  <= '0;
      wait_cnt   <= '0;
      abort_pend <= 1'b0;
      aborted    <= 1'b0;
      hdr        <= 1'b0;
      data       <= '0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      part       <= part_nxt;
      parts      <= parts_nxt;
      remaining  <= remaining_nxt;
      wait_cnt   <= wait_cnt_nxt;
      abort_pend <= abort_pend_nxt;
      aborted    <= aborted_nxt;
      hdr        <= hdr_nxt;
      data       <= data_nxt;
    end
  end

  // Next-state logic: read sequencing, stream handshake and abort handling.
  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    part_nxt       = part;
    parts_nxt      = parts;
    remaining_nxt  = remaining;
    wait_cnt_nxt   = wait_cnt;
    abort_pend_nxt = abort_pend;
    aborted_nxt    = aborted;
    hdr_nxt        = hdr;
    data_nxt       = data;

    case (state)
      IDLE: begin
        // Start together with abort is dropped on purpose.
        if (start_i && !abort_i) begin
          idx_nxt        = start_index_i;
          part_nxt       = '0;
          parts_nxt      = eff_parts(n_parts_i);
          remaining_nxt  = count_i;
          abort_pend_nxt = 1'b0;
          aborted_nxt    = 1'b0;
          hdr_nxt        = 1'b0;
          if (count_i == '0) begin
            state_nxt = DONE;
          end
`ifdef ILA_READOUT_HEADER_EN
          else begin
            hdr_nxt   = 1'b1;
            data_nxt  = header_word(count_i, eff_parts(n_parts_i));
            state_nxt = SEND;
          end
`else
          else begin
            state_nxt = SET;
          end
`endif
        end
      end

      SET: begin
        if (abort_i) begin
          aborted_nxt = 1'b1;
          state_nxt   = DONE;
        end else if (RD_LAT == 1) begin
          data_nxt  = value_i;
          state_nxt = SEND;
        end else begin
          wait_cnt_nxt = WAIT_LOAD;
          state_nxt    = WAIT;
        end
      end

      WAIT: begin
        // An abort here discards the word still in flight from the buffer.
        if (abort_i) begin
          aborted_nxt = 1'b1;
          state_nxt   = DONE;
        end else if (wait_cnt == WCNT_W'(1)) begin
          wait_cnt_nxt = '0;
          data_nxt     = value_i;
          state_nxt    = SEND;
        end else begin
          wait_cnt_nxt = wait_cnt - WCNT_W'(1);
        end
      end

      SEND: begin
        // A beat on offer is never withdrawn; abort waits for its handshake.
        if (abort_i) begin
          abort_pend_nxt = 1'b1;
        end
        if (tready_i) begin
          if (abort_i || abort_pend) begin
            aborted_nxt = 1'b1;
            state_nxt   = DONE;
          end else if (hdr) begin
            hdr_nxt   = 1'b0;
            state_nxt = SET;
          end else if (!last_part) begin
            part_nxt  = part + SEL_W'(1);
            state_nxt = SET;
          end else if (remaining > REM_W'(1)) begin
            part_nxt      = '0;
            idx_nxt       = idx + BUFFER_W'(1);
            remaining_nxt = remaining - REM_W'(1);
            state_nxt     = SET;
          end else begin
            state_nxt = DONE;
          end
        end
      end

      DONE: begin
        abort_pend_nxt = 1'b0;
        state_nxt      = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ila_readout_ctrl.sv
// Directed bench for ila_readout_ctrl with a small ILA buffer model and
// scoreboards for buffer writes and stream beats.
module tb_ila_readout_ctrl;

  localparam int DATA_W   = 32;
  localparam int BUFFER_W = 10;
  localparam int SEL_W    = 4;
  localparam int RD_LAT   = 2;
`ifdef ILA_READOUT_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic                abort = 1'b0;
  logic [BUFFER_W-1:0] start_index = '0;
  logic [BUFFER_W:0]   count = '0;
  logic [SEL_W-1:0]    n_parts = '0;
  logic                index_wen;
  logic [BUFFER_W-1:0] index;
  logic                sel_wen;
  logic [SEL_W-1:0]    sel;
  logic [DATA_W-1:0]   value;
  logic [DATA_W-1:0]   tdata;
  logic                tvalid;
  logic                tready = 1'b1;
  logic                tlast;
  logic                busy;
  logic                done;
  logic                aborted;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  typedef struct packed {
    logic [BUFFER_W-1:0] idx;
    logic [SEL_W-1:0]    sel;
  } wr_t;

  beat_t exp_beats[$];
  wr_t   exp_wr[$];
  int    hs_cyc[$];
  int    checks = 0;
  int    errors = 0;
  int    cycle = 0;
  int    done_pulses = 0;
  int    tlast_hs = 0;

  logic [BUFFER_W-1:0] mem_idx = '0;
  logic [SEL_W-1:0]    mem_sel = '0;

  always #5 clk = ~clk;

  ila_readout_ctrl #(
    .DATA_W  (DATA_W),
    .BUFFER_W(BUFFER_W),
    .SEL_W   (SEL_W),
    .RD_LAT  (RD_LAT)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .start_i      (start),
    .abort_i      (abort),
    .start_index_i(start_index),
    .count_i      (count),
    .n_parts_i    (n_parts),
    .index_wen_o  (index_wen),
    .index_o      (index),
    .sel_wen_o    (sel_wen),
    .sel_o        (sel),
    .value_i      (value),
    .tdata_o      (tdata),
    .tvalid_o     (tvalid),
    .tready_i     (tready),
    .tlast_o      (tlast),
    .busy_o       (busy),
    .done_o       (done),
    .aborted_o    (aborted)
  );

  function automatic logic [DATA_W-1:0] exp_val(input logic [BUFFER_W-1:0] i,
                                                input logic [SEL_W-1:0] s);
    return {4'hC, s, 8'h5A, 6'b000000, i};
  endfunction

  // Buffer model: registered index/select, value valid the cycle after SET.
  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (index_wen) mem_idx <= index;
    if (sel_wen)   mem_sel <= sel;
  end
  assign value = exp_val(mem_idx, mem_sel);

  // Monitor: scoreboards, hold-under-backpressure, done/tlast counting.
  initial begin
    logic              stall;
    logic [DATA_W-1:0] stall_data;
    logic              stall_last;
    beat_t             b;
    wr_t               w;
    stall = 1'b0;
    stall_data = '0;
    stall_last = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (stall) begin
          checks++;
          assert (tvalid === 1'b1 && tdata === stall_data && tlast === stall_last) else begin
            errors++;
            $error("FAIL hold: valid=%b data=%h last=%b, want valid=1 data=%h last=%b",
                   tvalid, tdata, tlast, stall_data, stall_last);
          end
        end
        stall      = (tvalid === 1'b1) && (tready === 1'b0);
        stall_data = tdata;
        stall_last = tlast;
        if (index_wen === 1'b1 || sel_wen === 1'b1) begin
          checks++;
          assert (exp_wr.size() > 0) else begin
            errors++;
            $error("FAIL wr_extra: index=%0d sel=%0d, want no write", index, sel);
          end
          if (exp_wr.size() > 0) begin
            w = exp_wr.pop_front();
            checks++;
            assert (index_wen === 1'b1 && sel_wen === 1'b1 && index === w.idx && sel === w.sel) else begin
              errors++;
              $error("FAIL wr: wen=%b/%b index=%0d sel=%0d, want 1/1 index=%0d sel=%0d",
                     index_wen, sel_wen, index, sel, w.idx, w.sel);
            end
          end
        end
        if (tvalid === 1'b1 && tready === 1'b1) begin
          hs_cyc.push_back(cycle);
          if (tlast === 1'b1) tlast_hs++;
          checks++;
          assert (exp_beats.size() > 0) else begin
            errors++;
            $error("FAIL beat_extra: data=%h last=%b, want no beat", tdata, tlast);
          end
          if (exp_beats.size() > 0) begin
            b = exp_beats.pop_front();
            checks++;
            assert (tdata === b.data && tlast === b.last) else begin
              errors++;
              $error("FAIL beat: data=%h last=%b, want data=%h last=%b", tdata, tlast, b.data, b.last);
            end
          end
        end
        if (done === 1'b1) done_pulses++;
      end else begin
        stall = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {index_wen, index, sel_wen, sel, tdata, tvalid, tlast, busy, done, aborted}, 64'd0);
  endtask

  task automatic queue_readout(input int si, input int cnt, input int np,
                               input int nwr, input int nbeat);
    int    npe;
    int    bn;
    beat_t bt;
    wr_t   w;
    npe = (np == 0) ? 1 : np;
`ifdef ILA_READOUT_HEADER_EN
    if (cnt > 0) begin
      bt.data        = '0;
      bt.data[15:0]  = 16'(cnt);
      bt.data[23:16] = 8'(npe);
      bt.last        = 1'b0;
      exp_beats.push_back(bt);
    end
`endif
    bn = 0;
    for (int s = 0; s < cnt; s++) begin
      for (int p = 0; p < npe; p++) begin
        w.idx = BUFFER_W'((si + s) % (1 << BUFFER_W));
        w.sel = SEL_W'(p);
        if (bn < nwr) exp_wr.push_back(w);
        if (bn < nbeat) begin
          bt.data = exp_val(w.idx, w.sel);
          bt.last = (s == cnt - 1) && (p == npe - 1);
          exp_beats.push_back(bt);
        end
        bn++;
      end
    end
  endtask

  task automatic pulse_start(input int si, input int cnt, input int np);
    start_index = BUFFER_W'(si);
    count       = (BUFFER_W + 1)'(cnt);
    n_parts     = SEL_W'(np);
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  task automatic wait_tvalid(input string tag, input int budget);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (tvalid === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    chk(tag, 64'(found), 64'd1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    chk(tag, 64'(found), 64'd1);
  endtask

  task automatic finish_checks(input string tag, input int d0, input int t0,
                               input bit exp_ab, input int exp_tl);
    repeat (2) @(negedge clk);
    chk({tag, "_beats_left"}, 64'(exp_beats.size()), 64'd0);
    chk({tag, "_wr_left"}, 64'(exp_wr.size()), 64'd0);
    chk({tag, "_aborted"}, 64'(aborted), 64'(exp_ab));
    chk({tag, "_done_pulses"}, 64'(done_pulses - d0), 64'd1);
    chk({tag, "_tlast_beats"}, 64'(tlast_hs - t0), 64'(exp_tl));
    chk({tag, "_busy_end"}, 64'(busy), 64'd0);
  endtask

  task automatic run_and_check(input string tag, input int si, input int cnt,
                               input int np, input int budget);
    int d0;
    int t0;
    d0 = done_pulses;
    t0 = tlast_hs;
    queue_readout(si, cnt, np, 1 << 30, 1 << 30);
    pulse_start(si, cnt, np);
    @(negedge clk);
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    chk({tag, "_aborted_clr"}, 64'(aborted), 64'd0);
    wait_done({tag, "_done_seen"}, budget);
    finish_checks(tag, d0, t0, 1'b0, 1);
  endtask

  initial begin
    int d0;
    int t0;
    int k;
    bit found;

    // Reset
    rst_n = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk_all_zero("reset_outputs");
    tick();
    rst_n = 1'b1;
    tick();

    // 1: basic readout with beat spacing
    tready = 1'b1;
    hs_cyc.delete();
    run_and_check("basic", 5, 3, 2, 200);
    chk("basic_nbeats", 64'(hs_cyc.size()), 64'(6 + HDR));
    for (int i = 1; i < hs_cyc.size(); i++) begin
      chk("basic_gap", 64'(hs_cyc[i] - hs_cyc[i-1]), 64'd3);
    end

    // 2: back-pressure on beat 2
    d0 = done_pulses;
    t0 = tlast_hs;
    queue_readout(40, 3, 2, 1 << 30, 1 << 30);
    pulse_start(40, 3, 2);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tvalid === 1'b1 && tready === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    chk("bp_first_hs", 64'(found), 64'd1);
    tick();
    tready = 1'b0;
    wait_tvalid("bp_beat2_valid", 50);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_valid_held", 64'(tvalid), 64'd1);
      chk("bp_no_wen", 64'(index_wen), 64'd0);
    end
    tick();
    tready = 1'b1;
    wait_done("bp_done_seen", 200);
    finish_checks("bp", d0, t0, 1'b0, 1);

    // 3: index wrap-around
    run_and_check("wrap", 1022, 4, 1, 200);

    // 4a: zero count
    d0 = done_pulses;
    pulse_start(3, 0, 2);
    @(negedge clk);
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_busy", 64'(busy), 64'd1);
    chk("zero_no_beat", 64'({tvalid, index_wen, sel_wen}), 64'd0);
    @(negedge clk);
    chk("zero_done_end", 64'({done, busy}), 64'd0);
    chk("zero_done_pulses", 64'(done_pulses - d0), 64'd1);

    // 4b: full buffer, n_parts 0 means one part
    run_and_check("full", 7, 1024, 0, 5000);

    // 5a: abort while waiting for beat 3's word
    d0 = done_pulses;
    t0 = tlast_hs;
    queue_readout(10, 2, 2, 3, 2);
    pulse_start(10, 2, 2);
    k = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (index_wen === 1'b1) k++;
      if (k == 3) break;
    end
    chk("abw_third_set", 64'(k), 64'd3);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_done("abw_done_seen", 20);
    finish_checks("abw", d0, t0, 1'b1, 0);

    // 5b: abort during a stalled first beat
    tready = 1'b0;
    d0 = done_pulses;
    t0 = tlast_hs;
    queue_readout(100, 3, 1, 1 - HDR, 1 - HDR);
    pulse_start(100, 3, 1);
    wait_tvalid("abs_valid", 50);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("abs_held", 64'({tvalid, done}), 64'b10);
    end
    tick();
    tready = 1'b1;
    wait_done("abs_done_seen", 20);
    finish_checks("abs", d0, t0, 1'b1, 0);

    // 5c: abort arriving on the tlast beat still delivers it
    tready = 1'b0;
    d0 = done_pulses;
    t0 = tlast_hs;
    queue_readout(200, 1, 1, 1 - HDR, 1 - HDR);
    pulse_start(200, 1, 1);
    wait_tvalid("abl_valid", 50);
    chk("abl_tlast", 64'(tlast), 64'(1 - HDR));
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tready = 1'b1;
    wait_done("abl_done_seen", 20);
    finish_checks("abl", d0, t0, 1'b1, 1 - HDR);

    // Start with simultaneous abort is ignored
    start_index = 10'd1;
    count       = 11'd2;
    n_parts     = 4'd1;
    start       = 1'b1;
    abort       = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk("start_abort_ignored", 64'({busy, index_wen, tvalid}), 64'd0);

    // 6: reset mid-SEND
    tready = 1'b0;
    queue_readout(50, 2, 1, 1 - HDR, 0);
    pulse_start(50, 2, 1);
    wait_tvalid("rst_valid", 50);
    chk("rst_wr_seen", 64'(exp_wr.size()), 64'd0);
    tick();
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    chk_all_zero("rst_mid_outputs");
    tick();
    rst_n = 1'b1;
    exp_beats.delete();
    exp_wr.delete();
    tready = 1'b1;
    tick();
    run_and_check("after_rst", 300, 2, 3, 200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
